// File: rtl/opcode_decoder.sv
// Keypad opcode consumer: turns level-held key qualifiers into a one-shot
// start / wait-for-done / optional writeback command sequence for the matrix ALU.
module opcode_decoder #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [2:0] opcode,
    input  logic       is_op,
    input  logic       is_result,
    input  logic       is_enter,
    input  logic       alu_done,
    output logic       alu_start,
    output logic [1:0] alu_op,
    output logic       result_wr,
    output logic       show_result,
    output logic       enter_pulse,
    output logic       busy,
    output logic       err,
    output logic       cmd_drop
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        WRITE,
        ERR
    } state_t;

    state_t           state;
    logic [1:0]       op_reg;
    logic             result_req;
    logic             is_op_q;
    logic             is_enter_q;
    logic [CNT_W-1:0] cnt;

    logic op_edge;
    logic ent_edge;

    // Maps the encoder opcode to the ALU function code; 2'b00 marks invalid.
    function automatic logic [1:0] decode_op(input logic [2:0] code);
        case (code)
            3'b001:  decode_op = 2'b01;
            3'b010:  decode_op = 2'b10;
            default: decode_op = 2'b00;
        endcase
    endfunction

    assign op_edge  = is_op & ~is_op_q;
    assign ent_edge = is_enter & ~is_enter_q;

    assign alu_start = (state == START);
    assign result_wr = (state == WRITE);
    assign err       = (state == ERR);
    assign busy      = (state != IDLE);
    assign alu_op    = ((state == START) || (state == WAIT)) ? op_reg : 2'b00;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            op_reg      <= 2'b00;
            result_req  <= 1'b0;
            show_result <= 1'b0;
            is_op_q     <= 1'b0;
            is_enter_q  <= 1'b0;
            cnt         <= '0;
            enter_pulse <= 1'b0;
            cmd_drop    <= 1'b0;
        end else begin
            // Edge history tracks the keys in every state so a held key never fires late.
            is_op_q     <= is_op;
            is_enter_q  <= is_enter;
            enter_pulse <= 1'b0;
            cmd_drop    <= 1'b0;

            case (state)
                IDLE: begin
                    if (op_edge) begin
                        if (decode_op(opcode) != 2'b00) begin
                            op_reg      <= decode_op(opcode);
                            result_req  <= is_result;
                            show_result <= 1'b0;
                            state       <= START;
                        end else begin
                            state <= ERR;
                        end
                    end else if (ent_edge) begin
                        enter_pulse <= 1'b1;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the final count still completes normally.
                    if (alu_done) begin
                        state <= result_req ? WRITE : IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    show_result <= 1'b1;
                    state       <= IDLE;
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if ((state != IDLE) && (op_edge || ent_edge)) begin
                cmd_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_opcode_decoder.sv
// Directed bench for opcode_decoder: hand-computed per-cycle expectations,
// inputs driven and outputs sampled 1ns after each rising edge.
module tb_opcode_decoder;

    logic       clk;
    logic       nrst;
    logic [2:0] opcode;
    logic       is_op;
    logic       is_result;
    logic       is_enter;
    logic       alu_done;
    logic       alu_start;
    logic [1:0] alu_op;
    logic       result_wr;
    logic       show_result;
    logic       enter_pulse;
    logic       busy;
    logic       err;
    logic       cmd_drop;

    int checks = 0;
    int errors = 0;

    opcode_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .opcode      (opcode),
        .is_op       (is_op),
        .is_result   (is_result),
        .is_enter    (is_enter),
        .alu_done    (alu_done),
        .alu_start   (alu_start),
        .alu_op      (alu_op),
        .result_wr   (result_wr),
        .show_result (show_result),
        .enter_pulse (enter_pulse),
        .busy        (busy),
        .err         (err),
        .cmd_drop    (cmd_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    // Packed view: {alu_start, alu_op[1:0], result_wr, show_result, enter_pulse, busy, err, cmd_drop}
    function automatic logic [8:0] outs();
        outs = {alu_start, alu_op, result_wr, show_result, enter_pulse, busy, err, cmd_drop};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_start;
        int n_drop;
        int n_err;
        int bad;

        nrst      = 1'b0;
        opcode    = 3'b000;
        is_op     = 1'b0;
        is_result = 1'b0;
        is_enter  = 1'b0;
        alu_done  = 1'b0;

        #3;
        check("reset_outs", 16'(outs()), 16'h000);
        @(posedge clk);
        #1 nrst = 1'b1;

        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (outs() !== 9'h000) bad++;
        end
        check("idle_10_cycles", 16'(bad), 16'd0);

        // Add with writeback, key held long after the first edge.
        opcode = 3'b001; is_op = 1'b1; is_result = 1'b1;
        tick();
        check("add_start", 16'(outs()), 16'(9'b1_01_0_0_0_1_0_0));
        tick();
        check("add_wait", 16'(outs()), 16'(9'b0_01_0_0_0_1_0_0));
        tick();
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("add_write", 16'(outs()), 16'(9'b0_00_1_0_0_1_0_0));
        tick();
        check("add_idle_show", 16'(outs()), 16'(9'b0_00_0_1_0_0_0_0));
        n_start = 0; n_drop = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_start += int'(alu_start);
            n_drop  += int'(cmd_drop);
        end
        check("add_held_no_restart", 16'(n_start), 16'd0);
        check("add_held_no_drop", 16'(n_drop), 16'd0);
        is_op = 1'b0;
        tick();

        // Subtract without writeback.
        opcode = 3'b010; is_op = 1'b1; is_result = 1'b0;
        tick();
        check("sub_start", 16'(outs()), 16'(9'b1_10_0_0_0_1_0_0));
        tick();
        check("sub_wait_op", 16'(alu_op), 16'h2);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("sub_done_idle", 16'(outs()), 16'h000);
        tick();
        check("sub_no_write", 16'(outs()), 16'h000);
        is_op = 1'b0;
        tick();

        // Invalid opcode.
        opcode = 3'b011; is_op = 1'b1;
        tick();
        check("inv_err", 16'(outs()), 16'(9'b0_00_0_0_0_1_1_0));
        tick();
        check("inv_back_idle", 16'(outs()), 16'h000);
        is_op = 1'b0;
        tick();

        // Timeout: 16 WAIT cycles without done.
        opcode = 3'b001; is_op = 1'b1; is_result = 1'b1;
        tick();
        tick();
        n_err = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_err += int'(err);
        end
        check("to_no_early_err", 16'(n_err), 16'd0);
        check("to_last_wait", 16'(outs()), 16'(9'b0_01_0_0_0_1_0_0));
        tick();
        check("to_err", 16'(outs()), 16'(9'b0_00_0_0_0_1_1_0));
        tick();
        check("to_idle", 16'(outs()), 16'h000);
        is_op = 1'b0;
        tick();

        // Done on the last WAIT cycle beats the timeout.
        is_op = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("late_done_write", 16'(outs()), 16'(9'b0_00_1_0_0_1_0_0));
        tick();
        check("late_done_show", 16'(outs()), 16'(9'b0_00_0_1_0_0_0_0));
        is_op = 1'b0;
        tick();

        // Edges while busy are dropped; reset mid-WAIT.
        opcode = 3'b010; is_op = 1'b1; is_result = 1'b0;
        tick();
        check("drop_start_show_clr", 16'(outs()), 16'(9'b1_10_0_0_0_1_0_0));
        is_op = 1'b0;
        tick();
        is_op = 1'b1;
        tick();
        check("drop_op_edge", 16'(outs()), 16'(9'b0_10_0_0_0_1_0_1));
        is_enter = 1'b1;
        tick();
        check("drop_ent_edge", 16'(outs()), 16'(9'b0_10_0_0_0_1_0_1));
        tick();
        check("drop_cleared", 16'(outs()), 16'(9'b0_10_0_0_0_1_0_0));
        #2 nrst = 1'b0;
        #1;
        check("async_reset_mid_wait", 16'(outs()), 16'h000);
        is_op = 1'b0; is_enter = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
        check("post_reset_idle", 16'(outs()), 16'h000);

        // Enter in IDLE, then op+enter together.
        is_enter = 1'b1;
        tick();
        check("enter_pulse", 16'(outs()), 16'(9'b0_00_0_0_1_0_0_0));
        tick();
        check("enter_held_once", 16'(outs()), 16'h000);
        is_enter = 1'b0;
        tick();
        opcode = 3'b001; is_op = 1'b1; is_enter = 1'b1; is_result = 1'b0;
        tick();
        check("op_beats_enter", 16'(outs()), 16'(9'b1_01_0_0_0_1_0_0));
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("combo_done_idle", 16'(outs()), 16'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
